// File: rtl/ctrl_trace_encoder.sv
// ---------------------------------------------------------------------------
// ctrl_trace_encoder
//
// Purpose:
//   Re-encodes the decoded control bundle back into the 3-bit opcode, tags
//   each accepted sample with a wrapping sequence number and buffers the
//   resulting record in a FIFO that drains over a valid/ready handshake.
//   Bundles that match no legal opcode are still recorded, flagged illegal.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   SEQW   sequence-tag width, wraps modulo 2^SEQW
//
// Ports:
//   Clk        in   clock, all state on rising edge
//   Reset      in   synchronous active-low reset
//   in_valid   in   control bundle is valid this cycle
//   Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Move, MemRead  in  control bits
//   ALUOp      in   [2:0] decoded ALU op
//   clr_ovf    in   clears sticky overflow (and statistics counters)
//   out_valid  out  FIFO head holds a record
//   out_ready  in   consumer accepts the head this cycle
//   out_data   out  {illegal, opcode[2:0], seq[SEQW-1:0]}
//   overflow   out  sticky: a sample was dropped while full
//   fifo_cnt   out  current occupancy 0..DEPTH
//
// Optional feature (macro CTRL_TRACE_STATS_EN):
//   illegal_cnt out [15:0] saturating count of pushed illegal records
//   drop_cnt    out [15:0] saturating count of dropped samples
// ---------------------------------------------------------------------------
module ctrl_trace_encoder #(
    parameter int DEPTH = 8,
    parameter int SEQW  = 8
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    in_valid,
    input  logic                    Branch,
    input  logic                    MemtoReg,
    input  logic                    MemWrite,
    input  logic                    ALUSrc,
    input  logic                    RegWrite,
    input  logic                    Move,
    input  logic                    MemRead,
    input  logic [2:0]              ALUOp,
    input  logic                    clr_ovf,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEQW+3:0]         out_data,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fifo_cnt
`ifdef CTRL_TRACE_STATS_EN
    ,
    output logic [15:0]             illegal_cnt,
    output logic [15:0]             drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [SEQW+3:0] r_mem [DEPTH];
    logic [AW-1:0]   r_rdPtr;
    logic [AW-1:0]   r_wrPtr;
    logic [CW-1:0]   r_cnt;
    logic [SEQW-1:0] r_seq;
    logic            r_overflow;

    logic [9:0]      w_bundle;
    logic [2:0]      w_opcode;
    logic            w_illegal;
    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;

    assign w_bundle = {Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Move, MemRead, ALUOp};

    // Bundle -> opcode. MemtoReg is a don't-care only for store and beq.
    always_comb begin
        w_opcode  = ALUOp;
        w_illegal = 1'b0;
        casez (w_bundle)
            10'b0000100_000: w_opcode = 3'b000;
            10'b0000100_001: w_opcode = 3'b001;
            10'b0100101_101: w_opcode = 3'b010;
            10'b0?10001_110: w_opcode = 3'b011;
            10'b0001110_100: w_opcode = 3'b100;
            10'b0000100_111: w_opcode = 3'b101;
            10'b0000100_010: w_opcode = 3'b110;
            10'b1?01000_011: w_opcode = 3'b111;
            default: begin
                w_opcode  = ALUOp;
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts a sample when the head leaves the same cycle.
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && !w_push;

    // Record storage; stale entries are never visible because out_data is
    // gated by occupancy, so the array needs no reset.
    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {w_illegal, w_opcode, r_seq};
        end
    end

    // Pointers, occupancy, sequence tag and sticky overflow.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_cnt      <= '0;
            r_seq      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                r_seq   <= r_seq + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // A new drop takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rdPtr];
    assign overflow  = r_overflow;
    assign fifo_cnt  = r_cnt;

`ifdef CTRL_TRACE_STATS_EN
    logic [15:0] r_illegalCnt;
    logic [15:0] r_dropCnt;
    logic [15:0] w_illegalBase;
    logic [15:0] w_dropBase;

    // clr_ovf zeroes the counters first; an event in the same cycle then
    // counts from zero.
    assign w_illegalBase = clr_ovf ? 16'h0000 : r_illegalCnt;
    assign w_dropBase    = clr_ovf ? 16'h0000 : r_dropCnt;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_illegalCnt <= '0;
            r_dropCnt    <= '0;
        end else begin
            if (w_push && w_illegal && (w_illegalBase != 16'hFFFF)) begin
                r_illegalCnt <= w_illegalBase + 16'd1;
            end else begin
                r_illegalCnt <= w_illegalBase;
            end
            if (w_drop && (w_dropBase != 16'hFFFF)) begin
                r_dropCnt <= w_dropBase + 16'd1;
            end else begin
                r_dropCnt <= w_dropBase;
            end
        end
    end

    assign illegal_cnt = r_illegalCnt;
    assign drop_cnt    = r_dropCnt;
`else
    // Statistics disabled: no counters or ports are built.
`endif

endmodule
